// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle logic/arith/shift ops and iterative
// unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        operation request, accepted only while busy=0
//   ALUOperation 4-bit opcode
//   A, B         operands (WIDTH bits)
//   shamt        shift amount (SHW bits)
//   busy         high while MULTU/DIVU iterate
//   done         one-cycle pulse marking a valid result
//   ALUResult    registered result
//   Zero         registered flag, ALUResult==0
//   HI, LO       multiply/divide result registers
//   DivByZero    set by DIVU with B==0, held until the next accepted op
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivByZero
);

    localparam logic [3:0] OpAnd   = 4'b0000;
    localparam logic [3:0] OpOr    = 4'b0001;
    localparam logic [3:0] OpNor   = 4'b0010;
    localparam logic [3:0] OpAdd   = 4'b0011;
    localparam logic [3:0] OpSub   = 4'b0100;
    localparam logic [3:0] OpSll   = 4'b0101;
    localparam logic [3:0] OpSrl   = 4'b0110;
    localparam logic [3:0] OpLui   = 4'b0111;
    localparam logic [3:0] OpSra   = 4'b1000;
    localparam logic [3:0] OpSlt   = 4'b1001;
    localparam logic [3:0] OpMultu = 4'b1010;
    localparam logic [3:0] OpDivu  = 4'b1011;
    localparam logic [3:0] OpMfhi  = 4'b1100;
    localparam logic [3:0] OpMflo  = 4'b1101;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    // MUL: {partial product high, remaining multiplier}; DIV: {remainder, quotient/dividend}
    logic [2*WIDTH-1:0] work_q, work_d;
    // Multiplicand or divisor captured at accept.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d, lo_q, lo_d;
    logic               zero_q, zero_d, done_q, done_d, dbz_q, dbz_d;

    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   single_res;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem, div_quo;

    assign accept = start && (state_q == StIdle);
    assign last   = (cnt_q == SHW'(WIDTH - 1));

    always_comb begin
        single_res = '0;
        case (ALUOperation)
            OpAnd:   single_res = A & B;
            OpOr:    single_res = A | B;
            OpNor:   single_res = ~(A | B);
            OpAdd:   single_res = A + B;
            OpSub:   single_res = A - B;
            OpSll:   single_res = A << shamt;
            OpSrl:   single_res = A >> shamt;
            OpLui:   single_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OpSra:   single_res = $signed(A) >>> shamt;
            OpSlt:   single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OpMfhi:  single_res = hi_q;
            OpMflo:  single_res = lo_q;
            default: single_res = '0;
        endcase
    end

    // Shift-add step: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole product right by one.
    assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

    // Restoring step: shift next dividend bit into the remainder and subtract
    // the divisor if it fits. The remainder stays below the divisor, so the
    // WIDTH-bit modular subtraction is exact.
    assign div_shift = work_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
    assign div_quo   = {work_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        zero_d  = zero_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    dbz_d = 1'b0;
                    cnt_d = '0;
                    if (ALUOperation == OpMultu) begin
                        state_d = StMul;
                        work_d  = {{WIDTH{1'b0}}, B};
                        opnd_d  = A;
                    end else if (ALUOperation == OpDivu && B == '0) begin
                        hi_d   = A;
                        lo_d   = '1;
                        res_d  = '1;
                        zero_d = 1'b0;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (ALUOperation == OpDivu) begin
                        state_d = StDiv;
                        work_d  = {{WIDTH{1'b0}}, A};
                        opnd_d  = B;
                    end else begin
                        res_d  = single_res;
                        zero_d = (single_res == '0);
                        done_d = 1'b1;
                    end
                end
            end
            StMul: begin
                work_d = mul_next;
                cnt_d  = cnt_q + SHW'(1);
                if (last) begin
                    hi_d    = mul_next[2*WIDTH-1:WIDTH];
                    lo_d    = mul_next[WIDTH-1:0];
                    res_d   = mul_next[WIDTH-1:0];
                    zero_d  = (mul_next[WIDTH-1:0] == '0);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StDiv: begin
                work_d = {div_rem, div_quo};
                cnt_d  = cnt_q + SHW'(1);
                if (last) begin
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                    res_d   = div_quo;
                    zero_d  = (div_quo == '0);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign DivByZero = dbz_q;

endmodule
